// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle CPU datapath.
// It steps each instruction through fetch, decode, execute, memory and
// write-back states and drives every datapath enable and mux select.
// The 2-bit ALUOp tells the ALU control decoder what to do:
// 00 = add, 01 = subtract/compare, 10 = decode the funct field.
//
// Optional feature: define MC_ADDI_EN to decode addi (opcode 001000)
// through ADDI_EXEC/ADDI_WB. When it is undefined, 001000 is illegal.
//
// Memory handshake: mem_ready is a ready-only handshake. The FSM holds a
// request (MemRead or MemWrite, with IorD) steady in FETCH, MEMREAD or
// MEMWRITE. The access completes in the cycle mem_ready is 1, and the FSM
// advances on that clock edge. It never withdraws a request before then.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXEC      = 4'd6,
    RTYPE_WB  = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t cur_state;
  state_t nxt_state;
  logic   is_load;
  logic   decode_ok;

  assign state = cur_state;

  // State register. Asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  // Record load vs store in DECODE. The opcode is not looked at again,
  // so changes on opcode after DECODE cannot steer MEMADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    is_load <= 1'b0;
    else if (cur_state == DECODE) is_load <= (opcode == OP_LW);
  end

  // Recognise the opcodes this FSM decodes.
  always_comb begin
    decode_ok = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: decode_ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI:                              decode_ok = 1'b1;
`endif
      default:                              decode_ok = 1'b0;
    endcase
  end

  // Next-state logic. Memory states wait for mem_ready.
  // Unused encodings return to FETCH.
  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:    nxt_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt_state = EXEC;
          OP_LW, OP_SW: nxt_state = MEMADDR;
          OP_BEQ:       nxt_state = BRANCH;
          OP_J:         nxt_state = JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt_state = ADDI_EXEC;
`endif
          default:      nxt_state = FETCH;
        endcase
      end
      MEMADDR:   nxt_state = is_load ? MEMREAD : MEMWRITE;
      MEMREAD:   nxt_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:     nxt_state = FETCH;
      MEMWRITE:  nxt_state = mem_ready ? FETCH : MEMWRITE;
      EXEC:      nxt_state = RTYPE_WB;
      RTYPE_WB:  nxt_state = FETCH;
      BRANCH:    nxt_state = FETCH;
      JUMP:      nxt_state = FETCH;
`ifdef MC_ADDI_EN
      ADDI_EXEC: nxt_state = ADDI_WB;
      ADDI_WB:   nxt_state = FETCH;
`endif
      default:   nxt_state = FETCH;
    endcase
  end

  // Output decode from the current state. While reset is high, every
  // enable is held at 0 and the mux selects show their FETCH values.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (reset) begin
      ALUSrcB = 2'b01;
    end else begin
      case (cur_state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~decode_ok;
        end
        MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RTYPE_WB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MC_ADDI_EN
        ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: begin
          ALUSrcB = 2'b00;
        end
      endcase
    end
  end

endmodule
